// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 2-flop input synchroniser, false-start rejection,
// 3-sample majority vote per bit, parity/frame/break flags and a valid/ack handshake.
module uart_rx_cfg #(
  parameter int DBIT        = 8,
  parameter int OVS         = 16,
  parameter int SB_TICK     = 16,
  parameter int PARITY_MODE = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx,
  input  logic            s_tick,
  input  logic            rx_ack,
  output logic [DBIT-1:0] dout,
  output logic            rx_done_tick,
  output logic            rx_valid,
  output logic            parity_err,
  output logic            frame_err,
  output logic            break_det,
  output logic            overrun
);

  localparam int  SMAX    = (OVS > SB_TICK) ? OVS : SB_TICK;
  localparam int  SW      = $clog2(SMAX);
  localparam int  NW      = $clog2(DBIT);
  localparam bit  USE_PAR = (PARITY_MODE == 1) || (PARITY_MODE == 2);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   s_q, s_d;
  logic [NW-1:0]   n_q, n_d;
  logic [DBIT-1:0] b_q, b_d;
  logic [1:0]      smp_q, smp_d;
  logic            pe_q, pe_d, fe_q, fe_d;
  logic            sync1_q, sync2_q;
  logic [DBIT-1:0] dout_q, dout_d;
  logic            done_q, done_d, valid_q, valid_d;
  logic            perr_q, perr_d, ferr_q, ferr_d, brk_q, brk_d, ovr_q, ovr_d;

  logic rx_s, vote, resolve, fe_now;

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    smp_d   = smp_q;
    pe_d    = pe_q;
    fe_d    = fe_q;
    dout_d  = dout_q;
    done_d  = 1'b0;
    valid_d = valid_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    brk_d   = brk_q;
    ovr_d   = ovr_q;
    fe_now  = fe_q;

    rx_s    = sync2_q;
    // the third sample is the live rx_s at the resolve tick
    vote    = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s) | (smp_q[1] & rx_s);
    resolve = s_tick && (s_q == SW'(OVS - 1));

    if (s_tick && (state_q == DATA || state_q == PAR || state_q == STOP)) begin
      if (s_q == SW'(OVS - 3)) smp_d[0] = rx_s;
      if (s_q == SW'(OVS - 2)) smp_d[1] = rx_s;
    end

    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          s_d     = '0;
          pe_d    = 1'b0;
          fe_d    = 1'b0;
        end
      end
      START: begin
        if (s_tick) begin
          if (s_q == SW'(OVS / 2 - 1)) begin
            s_d = '0;
            if (rx_s) begin
              state_d = IDLE;
            end else begin
              state_d = DATA;
              n_d     = '0;
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      DATA: begin
        if (resolve) begin
          s_d = '0;
          b_d = {vote, b_q[DBIT-1:1]};
          if (n_q == NW'(DBIT - 1)) state_d = USE_PAR ? PAR : STOP;
          else                      n_d     = n_q + 1'b1;
        end else if (s_tick) begin
          s_d = s_q + 1'b1;
        end
      end
      PAR: begin
        if (resolve) begin
          s_d     = '0;
          state_d = STOP;
          if (PARITY_MODE == 1) pe_d = vote ^ (^b_q);
          else                  pe_d = vote ^ ~(^b_q);
        end else if (s_tick) begin
          s_d = s_q + 1'b1;
        end
      end
      STOP: begin
        if (s_tick) begin
          // with SB_TICK == OVS the stop sample and frame end share one tick
          if (s_q == SW'(OVS - 1)) fe_now = ~vote;
          fe_d = fe_now;
          if (s_q == SW'(SB_TICK - 1)) begin
            state_d = IDLE;
            s_d     = '0;
            done_d  = 1'b1;
            dout_d  = b_q;
            perr_d  = pe_q;
            ferr_d  = fe_now;
            brk_d   = fe_now & (b_q == '0);
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (rx_ack && valid_q) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end
    if (done_d) begin
      valid_d = 1'b1;
      if (valid_q && !rx_ack) ovr_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      state_q <= IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      smp_q   <= '0;
      pe_q    <= 1'b0;
      fe_q    <= 1'b0;
      dout_q  <= '0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      brk_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      sync1_q <= rx;
      sync2_q <= sync1_q;
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      smp_q   <= smp_d;
      pe_q    <= pe_d;
      fe_q    <= fe_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
      valid_q <= valid_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      brk_q   <= brk_d;
      ovr_q   <= ovr_d;
    end
  end

  assign dout         = dout_q;
  assign rx_done_tick = done_q;
  assign rx_valid     = valid_q;
  assign parity_err   = perr_q;
  assign frame_err    = ferr_q;
  assign break_det    = brk_q;
  assign overrun      = ovr_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg (DBIT=8, even parity, OVS=16, 1 stop bit).
module tb_uart_rx_cfg;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rx = 1'b1;
  logic       s_tick = 1'b0;
  logic       rx_ack = 1'b0;
  logic [7:0] dout;
  logic       rx_done_tick, rx_valid, parity_err, frame_err, break_det, overrun;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int done_base;

  uart_rx_cfg #(.DBIT(8), .OVS(16), .SB_TICK(16), .PARITY_MODE(1)) dut (
    .clk(clk), .reset(reset), .rx(rx), .s_tick(s_tick), .rx_ack(rx_ack),
    .dout(dout), .rx_done_tick(rx_done_tick), .rx_valid(rx_valid),
    .parity_err(parity_err), .frame_err(frame_err), .break_det(break_det),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  // one s_tick every 4 clocks, changed on the falling edge
  initial begin
    int cnt = 0;
    forever begin
      @(negedge clk);
      s_tick = (cnt == 3);
      cnt = (cnt + 1) % 4;
    end
  end

  always @(negedge clk) if (rx_done_tick) done_cnt++;

  initial begin
    #3000000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic wait_tick();
    do @(posedge clk); while (s_tick !== 1'b1);
    @(negedge clk);
  endtask

  task automatic send_bit(input logic b, input logic spike);
    for (int p = 1; p <= 16; p++) begin
      rx = (spike && p == 7) ? ~b : b;
      wait_tick();
    end
  endtask

  task automatic idle_ticks(input int n);
    rx = 1'b1;
    for (int i = 0; i < n; i++) wait_tick();
  endtask

  task automatic send_frame(input logic [7:0] data, input logic par,
                            input logic stop_low, input logic spike);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(data[i], spike);
    send_bit(par, 1'b0);
    for (int p = 1; p <= 16; p++) begin
      rx = (stop_low && p <= 8) ? 1'b0 : 1'b1;
      wait_tick();
    end
    idle_ticks(20);
  endtask

  task automatic do_ack();
    @(negedge clk);
    rx_ack = 1'b1;
    @(negedge clk);
    rx_ack = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_val("rst_dout", 32'(dout), 32'h0);
    check_val("rst_valid", 32'(rx_valid), 32'h0);
    check_val("rst_done", 32'(rx_done_tick), 32'h0);
    check_val("rst_flags", {29'h0, parity_err, frame_err, break_det}, 32'h0);
    check_val("rst_overrun", 32'(overrun), 32'h0);
    reset = 1'b1;
    idle_ticks(10);

    // 1: clean 0xA5, even parity bit 0
    done_base = done_cnt;
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0);
    check_val("t1_dout", 32'(dout), 32'hA5);
    check_val("t1_valid", 32'(rx_valid), 32'h1);
    check_val("t1_perr", 32'(parity_err), 32'h0);
    check_val("t1_ferr", 32'(frame_err), 32'h0);
    check_val("t1_done_cnt", 32'(done_cnt - done_base), 32'h1);
    do_ack();
    check_val("t1_ack_clears_valid", 32'(rx_valid), 32'h0);

    // 2: wrong parity bit
    done_base = done_cnt;
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
    check_val("t2_dout", 32'(dout), 32'hA5);
    check_val("t2_perr", 32'(parity_err), 32'h1);
    check_val("t2_done_cnt", 32'(done_cnt - done_base), 32'h1);
    do_ack();

    // 3: 4-tick glitch rejected, then 0x3C
    done_base = done_cnt;
    rx = 1'b0;
    for (int i = 0; i < 4; i++) wait_tick();
    idle_ticks(24);
    check_val("t3_glitch_no_done", 32'(done_cnt - done_base), 32'h0);
    check_val("t3_glitch_no_valid", 32'(rx_valid), 32'h0);
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    check_val("t3_dout", 32'(dout), 32'h3C);
    check_val("t3_perr", 32'(parity_err), 32'h0);
    check_val("t3_done_cnt", 32'(done_cnt - done_base), 32'h1);
    do_ack();

    // 4: spike at the middle vote sample of every data bit
    send_frame(8'h55, 1'b0, 1'b0, 1'b1);
    check_val("t4_dout", 32'(dout), 32'h55);
    check_val("t4_perr", 32'(parity_err), 32'h0);
    check_val("t4_ferr", 32'(frame_err), 32'h0);
    do_ack();

    // 5: break frame, then 0x12 without ack -> overrun
    send_frame(8'h00, 1'b0, 1'b1, 1'b0);
    check_val("t5_ferr", 32'(frame_err), 32'h1);
    check_val("t5_break", 32'(break_det), 32'h1);
    check_val("t5_overrun_pre", 32'(overrun), 32'h0);
    send_frame(8'h12, 1'b0, 1'b0, 1'b0);
    check_val("t5_overrun", 32'(overrun), 32'h1);
    check_val("t5_dout", 32'(dout), 32'h12);
    check_val("t5_ferr_clr", 32'(frame_err), 32'h0);
    check_val("t5_break_clr", 32'(break_det), 32'h0);
    check_val("t5_valid", 32'(rx_valid), 32'h1);

    // 6: reset during data bit 4, then clean 0xF0
    done_base = done_cnt;
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) wait_tick();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check_val("t6_rst_dout", 32'(dout), 32'h0);
    check_val("t6_rst_valid", 32'(rx_valid), 32'h0);
    check_val("t6_rst_overrun", 32'(overrun), 32'h0);
    check_val("t6_rst_flags", {29'h0, parity_err, frame_err, break_det}, 32'h0);
    reset = 1'b1;
    idle_ticks(20);
    check_val("t6_abort_no_done", 32'(done_cnt - done_base), 32'h0);
    send_frame(8'hF0, 1'b0, 1'b0, 1'b0);
    check_val("t6_dout", 32'(dout), 32'hF0);
    check_val("t6_valid", 32'(rx_valid), 32'h1);
    check_val("t6_perr", 32'(parity_err), 32'h0);
    check_val("t6_overrun", 32'(overrun), 32'h0);
    check_val("t6_done_cnt", 32'(done_cnt - done_base), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
